// File: rtl/prog_prefetch_pkg.sv
// Shared types and constants for the Hack instruction prefetch front end.
package prefetch_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 15;

  localparam logic [DW_DEF-1:0] NOP       = 16'h0000;
  localparam logic [DW_DEF-1:0] FILL_WORD = NOP;

  typedef enum logic [1:0] {RST, RUN, REDIR} state_t;

  typedef struct packed {
    logic [DW_DEF-1:0] data;
    logic [AW_DEF-1:0] pc;
  } entry_t;
endpackage

// File: rtl/prog_prefetch_if.sv
// CPU <-> prefetch instruction port. master = CPU side, slave = prefetcher.
interface prog_prefetch_if import prefetch_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic          stall;
  logic          jmp;
  logic [AW-1:0] jmp_addr;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;

  modport master (output stall, jmp, jmp_addr, input instr, instr_pc, instr_valid);
  modport slave  (input stall, jmp, jmp_addr, output instr, instr_pc, instr_valid);
endinterface

// File: rtl/prog_prefetch_fifo.sv
// Prefetch FIFO: DEPTH entries (power of two), pointers wrap naturally on
// log2(DEPTH) bits, flush empties it in one cycle and wins over push/pop.
module prefetch_fifo #(
  parameter int W     = 31,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // storage write; contents need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/prog_prefetch.sv
// Hack CPU instruction front end: program ROM with 1-cycle synchronous read,
// prefetch FIFO and jump-redirect flushing. Delivers one PC-tagged word per
// unstalled cycle.
// Optional: define PREFETCH_PERF_EN to add saturating flush_cnt/bubble_cnt.
module prog_prefetch import prefetch_pkg::*; #(
  parameter int              DW    = DW_DEF,
  parameter int              AW    = AW_DEF,
  parameter int              DEPTH = 4,
  parameter int              IL    = 17,
  parameter                  PRG   = "prog.mif",
  parameter logic [DW-1:0]   FILL  = FILL_WORD
) (
  input  logic         clk,
  input  logic         reset_n,
  prog_prefetch_if.slave bus
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]  flush_cnt,
  output logic [15:0]  bubble_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW:0] IL_W = (AW+1)'(IL);
  // PRG names the image the built-in incrementing table stands in for.
  localparam int unused_prg = $bits(PRG);

  state_t        state;
  logic [AW-1:0] fpc;
  logic          infl;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_pc;
  logic [DW-1:0] last_instr;
  logic [AW-1:0] last_pc;
  logic [DW+AW-1:0] head;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          pop, issue, vld;

  // program image: word i holds i; addresses past the image read FILL
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if ({1'b0, a} < IL_W) return DW'(a);
    return FILL;
  endfunction

  assign vld   = (count != '0);
  assign pop   = vld && !bus.stall && !bus.jmp;
  // entries held plus the one in flight, after this cycle's pop
  assign occ   = {1'b0, count} + (CW+1)'(infl) - (CW+1)'(pop);
  assign issue = (state != RST) && !bus.jmp && (occ < (CW+1)'(DEPTH));

  prefetch_fifo #(.W(DW+AW), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (infl),
    .pop    (pop),
    .flush  (bus.jmp),
    .din    ({rd_data, rd_pc}),
    .dout   (head),
    .count  (count)
  );

  // FSM, fetch PC and the synchronous ROM read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= RST;
      fpc     <= '0;
      infl    <= 1'b0;
      rd_data <= '0;
      rd_pc   <= '0;
    end else begin
      case (state)
        RST:     state <= RUN;
        RUN:     state <= bus.jmp ? REDIR : RUN;
        REDIR:   state <= bus.jmp ? REDIR : RUN;
        default: state <= RST;
      endcase
      infl <= issue;
      if (bus.jmp) fpc <= bus.jmp_addr;
      else if (issue) begin
        fpc     <= fpc + 1'b1;
        rd_data <= rom_word(fpc);
        rd_pc   <= fpc;
      end
    end
  end

  // remember the last head shown so outputs hold while the FIFO is empty
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_instr <= '0;
      last_pc    <= '0;
    end else if (vld) begin
      last_instr <= head[DW+AW-1:AW];
      last_pc    <= head[AW-1:0];
    end
  end

  assign bus.instr_valid = vld;
  assign bus.instr       = vld ? head[DW+AW-1:AW] : last_instr;
  assign bus.instr_pc    = vld ? head[AW-1:0]     : last_pc;

`ifdef PREFETCH_PERF_EN
  // saturating flush and bubble counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bus.jmp && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      if (!vld && state != RST && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_prog_prefetch.sv
// Randomised + directed bench for prog_prefetch against a queue-based model.
module tb_prog_prefetch;
  import prefetch_pkg::*;
  localparam int DW = 16, AW = 15, DEPTH = 4, IL = 17;
  localparam int AMAX = (1 << AW) - 1;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  prog_prefetch_if #(.DW(DW), .AW(AW)) bus ();
`ifdef PREFETCH_PERF_EN
  logic [15:0] flush_cnt, bubble_cnt;
`endif

  prog_prefetch #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .IL(IL)) dut (
    .clk(clk), .reset_n(rst_n), .bus(bus)
`ifdef PREFETCH_PERF_EN
    , .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model: queue of delivered-in-order words ----
  entry_t m_q[$];
  entry_t m_pend_e, m_last;
  bit     m_pend, m_run;
  int     m_fpc, m_fc, m_bc;

  function automatic logic [15:0] img(input int a);
    return (a < IL) ? 16'(a) : FILL_WORD;
  endfunction

  task automatic model(input bit r, input bit s, input bit j, input int a);
    bit vld, pop, iss;
    int occ;
    if (!r) begin
      m_q.delete(); m_pend = 0; m_run = 0; m_fpc = 0;
      m_last = '0; m_fc = 0; m_bc = 0;
      return;
    end
    vld = (m_q.size() != 0);
    if (j && m_fc < 16'hFFFF) m_fc++;
    if (!vld && m_run && m_bc < 16'hFFFF) m_bc++;
    pop = vld && !s && !j;
    if (j) begin
      m_q.delete(); m_pend = 0; m_fpc = a;
    end else begin
      occ = m_q.size() + int'(m_pend) - int'(pop);
      iss = m_run && (occ < DEPTH);
      if (pop) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_e);
      if (iss) begin
        m_pend_e.data = img(m_fpc);
        m_pend_e.pc   = AW'(m_fpc);
        m_fpc = (m_fpc + 1) % (AMAX + 1);
      end
      m_pend = iss;
    end
    m_run = 1;
  endtask

  // one clock: drive at negedge, model on the edge, compare at next negedge
  task automatic cyc(input bit s, input bit j, input int a, input bit r);
    rst_n = r; bus.stall = s; bus.jmp = j; bus.jmp_addr = AW'(a);
    @(posedge clk);
    model(r, s, j, a);
    @(negedge clk);
    if (m_q.size() != 0) m_last = m_q[0];
    chk("m_valid", 32'(bus.instr_valid), 32'(m_q.size() != 0));
    chk("m_instr", 32'(bus.instr), 32'(m_last.data));
    chk("m_pc",    32'(bus.instr_pc), 32'(m_last.pc));
`ifdef PREFETCH_PERF_EN
    chk("m_flush_cnt",  32'(flush_cnt),  32'(m_fc));
    chk("m_bubble_cnt", 32'(bubble_cnt), 32'(m_bc));
`endif
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", 32'(bus.instr), 0);
    chk("rst_pc",    32'(bus.instr_pc), 0);
    cyc(0, 0, 0, 1);                      // E0
  endtask

  // count bubble cycles after a jump, bounded
  task automatic count_bubbles(output int b);
    b = 0;
    for (int k = 0; k < 8 && !bus.instr_valid; k++) begin
      b++;
      cyc(0, 0, 0, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int b;
    bus.stall = 0; bus.jmp = 0; bus.jmp_addr = '0;
    @(negedge clk);

    // free run: valid two edges after release, incrementing PCs, FILL past IL
    do_reset();
    chk("rise_e0", 32'(bus.instr_valid), 0);
    cyc(0, 0, 0, 1);
    chk("rise_e1", 32'(bus.instr_valid), 0);
    cyc(0, 0, 0, 1);
    chk("rise_e2", 32'(bus.instr_valid), 1);
    for (int i = 0; i < 22; i++) begin
      chk("run_pc", 32'(bus.instr_pc), 32'(i));
      chk("run_instr", 32'(bus.instr), 32'(img(i)));
      cyc(0, 0, 0, 1);
    end

    // stall until full, then burst out 0..7
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1);
    chk("full_count", 32'(dut.u_fifo.count), 4);
    chk("full_fpc",   32'(dut.fpc), 4);
    for (int i = 0; i < 8; i++) begin
      chk("burst_valid", 32'(bus.instr_valid), 1);
      chk("burst_pc", 32'(bus.instr_pc), 32'(i));
      cyc(0, 0, 0, 1);
    end

    // jump to 12 with three entries queued
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("jmp_pre_count", 32'(dut.u_fifo.count), 3);
    cyc(0, 1, 12, 1);
    count_bubbles(b);
    chk("jmp_bubbles", 32'(b), 2);
    chk("jmp_pc0", 32'(bus.instr_pc), 12);
    cyc(0, 0, 0, 1);
    chk("jmp_pc1", 32'(bus.instr_pc), 13);

    // back-to-back jumps: last target wins
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 5, 1);
    cyc(0, 1, 9, 1);
    count_bubbles(b);
    chk("b2b_bubbles", 32'(b), 2);
    chk("b2b_pc", 32'(bus.instr_pc), 9);
`ifdef PREFETCH_PERF_EN
    chk("b2b_flush_cnt", 32'(flush_cnt), 2);
`endif

    // PC wrap at the top of the address space
    cyc(0, 1, AMAX, 1);
    count_bubbles(b);
    chk("wrap_pc0", 32'(bus.instr_pc), 32'(AMAX));
    chk("wrap_i0",  32'(bus.instr), 32'(FILL_WORD));
    cyc(0, 0, 0, 1);
    chk("wrap_pc1", 32'(bus.instr_pc), 0);
    chk("wrap_i1",  32'(bus.instr), 32'(FILL_WORD));

    // reset with jmp overrides the jump
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 20, 0);
    chk("rj_valid", 32'(bus.instr_valid), 0);
    chk("rj_instr", 32'(bus.instr), 0);
    chk("rj_pc",    32'(bus.instr_pc), 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rj_restart", 32'(bus.instr_pc), 0);
    chk("rj_rvalid",  32'(bus.instr_valid), 1);

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      bit s, j, r;
      int a;
      s = ($urandom_range(0, 2) == 0);
      j = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 199) != 0);
      a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 24))
                                      : AMAX - int'($urandom_range(0, 3));
      cyc(s, j, a, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
